// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, controller states and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_BIC = 3'b101,
    OP_MOV = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the datapath controller (master) and alu_mc (slave).
interface alu_mc_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   ALUControl;
  logic         busy;
  logic         done;
  logic [N-1:0] Result;
  logic [3:0]   ALUFlags;

  modport master (
    output start, a, b, ALUControl,
    input  busy, done, Result, ALUFlags
  );

  modport slave (
    input  start, a, b, ALUControl,
    output busy, done, Result, ALUFlags
  );
endinterface

// File: rtl/alu_mc_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per step, finishing early once the
// remaining multiplier bits are all zero.
module mul_iter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         finished,
  output logic [N-1:0] product
);
  localparam int CNTW = $clog2(N) + 1;

  logic [N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    acc_sum_s;
  logic [N-1:0]    mplier_shr_s;

  assign acc_sum_s    = acc_q + (mplier_q[0] ? mcand_q : {N{1'b0}});
  assign mplier_shr_s = mplier_q >> 1;
  // The product is taken from the sum of the current step so the final step needs no extra cycle.
  assign product      = acc_sum_s;
  assign finished     = step && ((cnt_q == CNTW'(1)) || (mplier_shr_s == {N{1'b0}}));

  // Next-state for the operand, accumulator and iteration registers.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = {N{1'b0}};
      cnt_d    = CNTW'(N);
    end else if (step) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_shr_s;
      acc_d    = acc_sum_s;
      cnt_d    = cnt_q - CNTW'(1);
    end else begin
      cnt_d    = cnt_q;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= {N{1'b0}};
      mplier_q <= {N{1'b0}};
      acc_q    <= {N{1'b0}};
      cnt_q    <= {CNTW{1'b0}};
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with start/done handshake, registered Result and NZCV flags.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise op 111 returns 0 in one cycle.
module alu_mc
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);
  alu_state_t   state_q, state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;

  alu_op_t      op_s;
  logic [N:0]   sum_s;
  logic [N-1:0] alu_res_s;
  logic         alu_c_s;
  logic         alu_v_s;
  logic         mul_go_s;
  logic         mul_fin_s;
  logic [N-1:0] mul_prod_s;

  function automatic logic [3:0] make_flags(input logic [N-1:0] res, input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = res[N-1];
    f[FLAG_Z] = (res == {N{1'b0}});
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign op_s = alu_op_t'(bus.ALUControl);

`ifdef ALU_MUL_EN
  logic mul_load_s;
  logic mul_step_s;

  assign mul_go_s   = (op_s == OP_MUL);
  assign mul_load_s = (state_q == IDLE) && bus.start && mul_go_s;
  assign mul_step_s = (state_q == MUL);

  mul_iter #(.N(N)) u_mul_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (mul_load_s),
    .step     (mul_step_s),
    .a        (bus.a),
    .b        (bus.b),
    .finished (mul_fin_s),
    .product  (mul_prod_s)
  );
`else
  assign mul_go_s   = 1'b0;
  assign mul_fin_s  = 1'b0;
  assign mul_prod_s = {N{1'b0}};
`endif

  // Single-cycle ops; SUB is a + ~b + 1 so C is the no-borrow carry.
  always_comb begin
    sum_s     = {(N+1){1'b0}};
    alu_res_s = {N{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (op_s)
      OP_ADD: begin
        sum_s     = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res_s = sum_s[N-1:0];
        alu_c_s   = sum_s[N];
        alu_v_s   = (bus.a[N-1] == bus.b[N-1]) && (sum_s[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        sum_s     = {1'b0, bus.a} + {1'b0, ~bus.b} + {{N{1'b0}}, 1'b1};
        alu_res_s = sum_s[N-1:0];
        alu_c_s   = sum_s[N];
        alu_v_s   = (bus.a[N-1] != bus.b[N-1]) && (sum_s[N-1] != bus.a[N-1]);
      end
      OP_AND:  alu_res_s = bus.a & bus.b;
      OP_ORR:  alu_res_s = bus.a | bus.b;
      OP_EOR:  alu_res_s = bus.a ^ bus.b;
      OP_BIC:  alu_res_s = bus.a & ~bus.b;
      OP_MOV:  alu_res_s = bus.b;
      default: alu_res_s = {N{1'b0}};
    endcase
  end

  // Controller next-state; Result/flags only move on the transition into DONE.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (bus.start && mul_go_s) begin
          state_d = MUL;
          busy_d  = 1'b1;
        end else if (bus.start) begin
          state_d  = DONE;
          busy_d   = 1'b1;
          done_d   = 1'b1;
          result_d = alu_res_s;
          flags_d  = make_flags(alu_res_s, alu_c_s, alu_v_s);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      MUL: begin
        if (mul_fin_s) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = mul_prod_s;
          flags_d  = make_flags(mul_prod_s, 1'b0, 1'b0);
        end else begin
          state_d = MUL;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {N{1'b0}};
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.Result   = result_q;
  assign bus.ALUFlags = flags_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (N=32); MUL checks follow the ALU_MUL_EN build option.
module tb_alu_mc;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   lat;

  alu_mc_if #(.N(32)) bus ();

  alu_mc #(.N(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int edges);
    bus.ALUControl = op;
    bus.a          = av;
    bus.b          = bv;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    edges     = 1;
    while (bus.done !== 1'b1 && edges < 64) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] av,
                           input logic [31:0] bv, input int exp_lat,
                           input logic [31:0] exp_res, input logic [3:0] exp_flags);
    int l;
    run_op(op, av, bv, l);
    check({tag, "_lat"}, 64'(l), 64'(exp_lat));
    check({tag, "_res"}, 64'(bus.Result), 64'(exp_res));
    check({tag, "_flags"}, 64'(bus.ALUFlags), 64'(exp_flags));
    tick();
  endtask

  initial begin
    int done_edge;
    int n_done;
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.a          = 32'h0;
    bus.b          = 32'h0;
    bus.ALUControl = 3'b000;
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_res", 64'(bus.Result), 64'd0);
    check("rst_flags", 64'(bus.ALUFlags), 64'd0);
    reset = 1'b0;
    tick();

    // ADD wrap to zero, then a start issued in DONE must be ignored.
    run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    check("add_lat", 64'(lat), 64'd1);
    check("add_res", 64'(bus.Result), 64'h0);
    check("add_flags", 64'(bus.ALUFlags), 64'(4'b0110));
    check("add_busy", 64'(bus.busy), 64'd1);
    bus.start      = 1'b1;
    bus.ALUControl = 3'b110;
    bus.b          = 32'h1234_5678;
    tick();
    bus.start = 1'b0;
    check("done_ign_done", 64'(bus.done), 64'd0);
    check("done_ign_busy", 64'(bus.busy), 64'd0);
    check("done_ign_res", 64'(bus.Result), 64'h0);
    tick();

    run_check("sub_ovf", 3'b001, 32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 4'b0011);
    run_check("sub_neg", 3'b001, 32'h0000_0003, 32'h0000_0005, 1, 32'hFFFF_FFFE, 4'b1000);
    run_check("and",     3'b010, 32'hF0F0_F0F0, 32'hFFFF_0000, 1, 32'hF0F0_0000, 4'b1000);
    run_check("orr",     3'b011, 32'hF0F0_F0F0, 32'hFFFF_0000, 1, 32'hFFFF_F0F0, 4'b1000);
    run_check("bic",     3'b101, 32'hF0F0_F0F0, 32'hFFFF_0000, 1, 32'h0000_F0F0, 4'b0000);
    run_check("mov0",    3'b110, 32'hDEAD_BEEF, 32'h0000_0000, 1, 32'h0000_0000, 4'b0100);

`ifdef ALU_MUL_EN
    // Full-length MUL with ADD starts in MUL and DONE that must be ignored.
    bus.ALUControl = 3'b111;
    bus.a          = 32'h0001_0001;
    bus.b          = 32'h8000_0000;
    bus.start      = 1'b1;
    tick();
    done_edge = 0;
    n_done    = 0;
    for (int i = 2; i <= 40; i++) begin
      if (i == 3 || i == 10 || i == 34) begin
        bus.start      = 1'b1;
        bus.ALUControl = 3'b000;
        bus.a          = 32'h1;
        bus.b          = 32'h1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done === 1'b1) begin
        n_done++;
        done_edge = i;
      end
      if (i == 20) check("mul_busy_mid", 64'(bus.busy), 64'd1);
    end
    bus.start = 1'b0;
    check("mul_done_edge", 64'(done_edge), 64'd33);
    check("mul_done_cnt", 64'(n_done), 64'd1);
    check("mul_res", 64'(bus.Result), 64'h8000_0000);
    check("mul_flags", 64'(bus.ALUFlags), 64'(4'b1000));

    run_check("mul_7x6", 3'b111, 32'd7, 32'd6, 4, 32'd42, 4'b0000);
    run_check("mul_bz",  3'b111, 32'd5, 32'd0, 2, 32'd0, 4'b0100);

    // Abort a multiply five cycles in.
    bus.ALUControl = 3'b111;
    bus.a          = 32'h0001_0001;
    bus.b          = 32'h8000_0000;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
`else
    run_check("op7_off", 3'b111, 32'd3, 32'd4, 1, 32'd0, 4'b0100);
    run_op(3'b000, 32'd1, 32'd1, lat);
    check("pre_rst_res", 64'(bus.Result), 64'd2);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_res", 64'(bus.Result), 64'd0);
    check("abort_flags", 64'(bus.ALUFlags), 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);

    run_check("eor", 3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000, 1, 32'h0F0F_F0F0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
